pipe_reg_chain: RTL and testbench
=================================

Name: pipe_reg_chain

Overview:
- Parametrised pipeline register chain: DEPTH stages of WIDTH-bit payload, each stage with its own valid bit.
- Uses a valid/ready handshake with bubble collapsing: a stage advances whenever it is empty or its successor advances.
- Supports a global flush and per-stage kill (squash), so IF/ID/EXE/MEM pipeline registers can be built as one generic block with hazard stall and branch-squash support.
- Exposes per-stage valid and occupancy for hazard/forwarding logic.

Parameters:
WIDTH, 32, payload width in bits (>=1)
DEPTH, 4, number of register stages (>=1)
RESET_DATA, 0, value loaded into every data stage on reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
in_valid  input  1  upstream offers in_data
in_ready  output  1  chain accepts in_data this cycle
in_data  input  WIDTH  payload entering stage 0
out_valid  output  1  last stage holds a live item
out_ready  input  1  downstream accepts out_data
out_data  output  WIDTH  payload of stage DEPTH-1
flush  input  1  squash all stages and block input this cycle
kill_stage  input  DEPTH  per-stage squash; bit i kills stage i
stage_valid  output  DEPTH  effective valid of each stage
occupancy  output  clog2(DEPTH+1)  registered count of valid stages

Behaviour:
- State per stage i: v[i], d[i]. Stage 0 is the input end; stage DEPTH-1 drives out_data.
- Reset: while rst=0, asynchronously v[*]=0, d[*]=RESET_DATA, occupancy=0. Outputs during reset: out_valid=0, in_ready=0, stage_valid=0, out_data=RESET_DATA. Reset asserted mid-transfer discards all items with no partial transfer.
- Effective valid: ev[i] = v[i] & ~kill_stage[i] & ~flush. stage_valid = ev. out_valid = ev[DEPTH-1].
- Advance chain (combinational):
  - adv[DEPTH-1] = ~ev[DEPTH-1] | out_ready
  - adv[i] = ~ev[i] | adv[i+1]
  - in_ready = adv[0] & ~flush & rst
  - No combinational path from in_valid to in_ready.
- Clock edge, per stage i, when adv[i]=1:
  - src valid = (i==0 ? in_valid & ~flush : ev[i-1])
  - v[i] <= src valid
  - d[i] <= src data only if src valid; otherwise d[i] holds.
- Clock edge, per stage i, when adv[i]=0: v[i] and d[i] hold. Kill cannot apply here because ev[i]=1 implies no kill.
- Killed item: its ev is 0, so its stage advances and the item is overwritten or dropped. A killed item is never transferred downstream or out.
- flush=1: all v cleared at the edge; the input is not accepted; out_valid=0, so no output transfer occurs that cycle. flush overrides kill_stage and out_ready.
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready. Simultaneous input and output with a full chain is allowed: throughput is 1 item/cycle, no bubble.
- Latency: an item accepted at edge t into an empty chain with out_ready=1 appears (out_valid=1) after edge t+DEPTH-1. With DEPTH=1, it appears right after the accept edge.
- Stall: out_ready=0 fills the chain from the output end. Internal bubbles collapse one stage per cycle. in_ready falls only when all DEPTH stages are valid and out_ready=0.
- occupancy: popcount of v, registered (reflects state after the last edge, before this cycle's kills). Range 0..DEPTH. Never wraps.
- Ordering: items leave in acceptance order. No duplication, no reordering.

Test Plan:
- Reset/latency: DEPTH=4, hold rst=0 → out_valid=0, out_data=0, occupancy=0. Release reset; send 0xA5A5A5A5 with out_ready=1 → out_valid=1 with that data exactly 3 edges after the accept edge, for 1 cycle.
- Full throughput: stream 0x1..0x10 back-to-back with out_ready=1 → in_ready stays 1; outputs 0x1..0x10 in order on consecutive cycles.
- Stall/fill: out_ready=0 while sending 0x1..0x6 → in_ready drops after 4 accepts, occupancy=4. Raise out_ready → 0x1..0x6 emerge in order, none lost.
- Bubble collapse: insert 0x1, idle 2 cycles, insert 0x2, with out_ready=0 → both reach stages 3 and 2, occupancy=2, in_ready=1.
- Kill: chain holds 0x1..0x4 (stage3=0x1) and out_ready=0; pulse kill_stage=4'b0100 (stage 2, item 0x2) → output sequence is 0x1, 0x3, 0x4; occupancy falls to 3.
- Flush plus async reset: full chain, assert flush with in_valid=1 and out_ready=1 → no transfer that cycle, occupancy=0 next cycle. Then refill and drop rst mid-cycle → outputs clear immediately, before the next clk edge.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// Generic valid/ready pipeline register chain with bubble collapsing,
// global flush and per-stage kill for building hazard-aware pipelines.
module pipe_reg_chain #(
    parameter int               WIDTH      = 32,
    parameter int               DEPTH      = 4,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       flush,
    input  logic [DEPTH-1:0]           kill_stage,
    output logic [DEPTH-1:0]           stage_valid,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] ev;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] src_v;
    logic [DEPTH-1:0] v_nxt;
    logic [WIDTH-1:0] d     [DEPTH];
    logic [WIDTH-1:0] src_d [DEPTH];
    logic [OW-1:0]    occ;
    logic [OW-1:0]    occ_nxt;

    // A stage may advance when it holds nothing live or its successor moves.
    always_comb begin
        ev           = v & ~kill_stage & {DEPTH{~flush}};
        adv          = '0;
        adv[DEPTH-1] = ~ev[DEPTH-1] | out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = ~ev[i] | adv[i+1];
        end
    end

    always_comb begin
        src_v    = '0;
        src_v[0] = in_valid & ~flush;
        src_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_v[i] = ev[i-1];
            src_d[i] = d[i-1];
        end
    end

    always_comb begin
        v_nxt   = '0;
        occ_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_nxt[i] = adv[i] ? src_v[i] : v[i];
            occ_nxt  = occ_nxt + OW'(v_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v   <= '0;
            occ <= '0;
        end else begin
            v   <= v_nxt;
            occ <= occ_nxt;
        end
    end

    // Payload only loads on a live transfer so idle stages keep old data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= RESET_DATA;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (adv[i] && src_v[i]) begin
                    d[i] <= src_d[i];
                end
            end
        end
    end

    assign in_ready    = adv[0] & ~flush & rst;
    assign out_valid   = ev[DEPTH-1];
    assign out_data    = d[DEPTH-1];
    assign stage_valid = ev;
    assign occupancy   = occ;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain: directed scenarios plus a
// randomized run against a slot-based behavioural model.
module tb_pipe_reg_chain;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int OW = 3;

    logic          clk        = 1'b0;
    logic          rst        = 1'b0;
    logic          in_valid   = 1'b0;
    logic          out_ready  = 1'b0;
    logic          flush      = 1'b0;
    logic [W-1:0]  in_data    = '0;
    logic [D-1:0]  kill_stage = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [D-1:0]  stage_valid;
    logic [OW-1:0] occupancy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [W-1:0] dut_out [$];
    int           dut_cyc [$];

    // Model: one slot per stage, items slide toward the output end.
    bit           mv [D];
    logic [W-1:0] md [D];

    pipe_reg_chain #(.WIDTH(W), .DEPTH(D), .RESET_DATA('0)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .flush       (flush),
        .kill_stage  (kill_stage),
        .stage_valid (stage_valid),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int m_occ();
        int c = 0;
        for (int i = 0; i < D; i++) c += int'(mv[i]);
        return c;
    endfunction

    function automatic logic [D-1:0] m_sv();
        logic [D-1:0] r;
        for (int i = 0; i < D; i++)
            r[i] = rst && mv[i] && !kill_stage[i] && !flush;
        return r;
    endfunction

    function automatic bit m_in_ready();
        logic [D-1:0] e = m_sv();
        if (!rst || flush) return 1'b0;
        if (e[D-1] && out_ready) e[D-1] = 1'b0;
        for (int i = D - 2; i >= 0; i--) begin
            if (e[i] && !e[i+1]) begin
                e[i+1] = 1'b1;
                e[i]   = 1'b0;
            end
        end
        return !e[0];
    endfunction

    task automatic m_clear();
        for (int i = 0; i < D; i++) begin
            mv[i] = 1'b0;
            md[i] = '0;
        end
    endtask

    task automatic m_commit();
        logic [D-1:0] nv;
        logic [W-1:0] nd [D];
        if (!rst) begin
            m_clear();
            return;
        end
        nv = m_sv();
        for (int i = 0; i < D; i++) nd[i] = md[i];
        if (nv[D-1] && out_ready) nv[D-1] = 1'b0;
        for (int i = D - 2; i >= 0; i--) begin
            if (nv[i] && !nv[i+1]) begin
                nv[i+1] = 1'b1;
                nd[i+1] = nd[i];
                nv[i]   = 1'b0;
            end
        end
        if (!nv[0] && !flush && in_valid) begin
            nv[0] = 1'b1;
            nd[0] = in_data;
        end
        for (int i = 0; i < D; i++) begin
            mv[i] = nv[i];
            md[i] = nd[i];
        end
    endtask

    task automatic tick();
        #1;
        if (out_valid && out_ready) begin
            dut_out.push_back(out_data);
            dut_cyc.push_back(cyc);
        end
        @(posedge clk);
        m_commit();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        in_valid  = 1'b1;
        in_data   = 32'hFFFF_FFFF;
        out_ready = 1'b1;
        tick();
        tick();
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_checks++;
        if (out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out_data: got %h want 0", out_data);
        end
        n_checks++;
        if (occupancy !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_occ: got %0d want 0", occupancy);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        n_checks++;
        if (stage_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_stage_valid: got %b want 0000", stage_valid);
        end
    endtask

    task automatic test_latency();
        int k;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hA5A5_A5A5;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lat_in_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        k = 0;
        while (k < 10) begin
            #1;
            if (out_valid) break;
            tick();
            k++;
        end
        n_checks++;
        if (k !== 3) begin
            n_fail++;
            $display("FAIL lat_edges: got %0d want 3", k);
        end
        n_checks++;
        if (out_data !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL lat_data: got %h want a5a5a5a5", out_data);
        end
        tick();
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_one_cycle: got %b want 0", out_valid);
        end
    endtask

    task automatic test_throughput();
        dut_out.delete();
        dut_cyc.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i + 1);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL thr_in_ready[%0d]: got %b want 1", i, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        n_checks++;
        if (dut_out.size() !== 16) begin
            n_fail++;
            $display("FAIL thr_count: got %0d want 16", dut_out.size());
        end
        for (int i = 0; i < dut_out.size() && i < 16; i++) begin
            n_checks++;
            if (dut_out[i] !== W'(i + 1)) begin
                n_fail++;
                $display("FAIL thr_data[%0d]: got %h want %h", i, dut_out[i], i + 1);
            end
            if (i > 0) begin
                n_checks++;
                if (dut_cyc[i] !== dut_cyc[i-1] + 1) begin
                    n_fail++;
                    $display("FAIL thr_gap[%0d]: got cycle %0d want %0d", i, dut_cyc[i], dut_cyc[i-1] + 1);
                end
            end
        end
    endtask

    task automatic test_stall_fill();
        int  idx = 0;
        bit  acc;
        dut_out.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            in_data = W'(idx + 1);
            #1;
            if (!in_ready) break;
            tick();
            idx++;
        end
        n_checks++;
        if (idx !== 4) begin
            n_fail++;
            $display("FAIL stall_accepts: got %0d want 4", idx);
        end
        n_checks++;
        if (occupancy !== 3'd4) begin
            n_fail++;
            $display("FAIL stall_occ: got %0d want 4", occupancy);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 30 && dut_out.size() < 6; k++) begin
            in_valid = idx < 6;
            in_data  = W'(idx + 1);
            #1;
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (dut_out.size() !== 6) begin
            n_fail++;
            $display("FAIL stall_count: got %0d want 6", dut_out.size());
        end
        for (int i = 0; i < dut_out.size() && i < 6; i++) begin
            n_checks++;
            if (dut_out[i] !== W'(i + 1)) begin
                n_fail++;
                $display("FAIL stall_data[%0d]: got %h want %h", i, dut_out[i], i + 1);
            end
        end
    endtask

    task automatic test_bubble();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        in_valid = 1'b1;
        in_data  = 32'h2;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        #1;
        n_checks++;
        if (stage_valid !== 4'b1100) begin
            n_fail++;
            $display("FAIL bub_stage_valid: got %b want 1100", stage_valid);
        end
        n_checks++;
        if (occupancy !== 3'd2) begin
            n_fail++;
            $display("FAIL bub_occ: got %0d want 2", occupancy);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bub_in_ready: got %b want 1", in_ready);
        end
        n_checks++;
        if (out_data !== 32'h1) begin
            n_fail++;
            $display("FAIL bub_out_data: got %h want 1", out_data);
        end
    endtask

    task automatic test_kill();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (occupancy !== 3'd4) begin
            n_fail++;
            $display("FAIL kill_pre_occ: got %0d want 4", occupancy);
        end
        kill_stage = 4'b0100;
        #1;
        n_checks++;
        if (stage_valid !== 4'b1011) begin
            n_fail++;
            $display("FAIL kill_stage_valid: got %b want 1011", stage_valid);
        end
        tick();
        kill_stage = 4'b0000;
        #1;
        n_checks++;
        if (occupancy !== 3'd3) begin
            n_fail++;
            $display("FAIL kill_occ: got %0d want 3", occupancy);
        end
        dut_out.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        n_checks++;
        if (dut_out.size() !== 3) begin
            n_fail++;
            $display("FAIL kill_count: got %0d want 3", dut_out.size());
        end
        if (dut_out.size() == 3) begin
            n_checks++;
            if (dut_out[0] !== 32'h1 || dut_out[1] !== 32'h3 || dut_out[2] !== 32'h4) begin
                n_fail++;
                $display("FAIL kill_seq: got %h %h %h want 1 3 4", dut_out[0], dut_out[1], dut_out[2]);
            end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h11 + W'(i);
            tick();
        end
        in_valid  = 1'b1;
        in_data   = 32'h99;
        out_ready = 1'b1;
        flush     = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_out_valid: got %b want 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_in_ready: got %b want 0", in_ready);
        end
        n_checks++;
        if (stage_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL flush_stage_valid: got %b want 0000", stage_valid);
        end
        dut_out.delete();
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (dut_out.size() !== 0) begin
            n_fail++;
            $display("FAIL flush_xfer: got %0d transfers want 0", dut_out.size());
        end
        n_checks++;
        if (occupancy !== 3'd0) begin
            n_fail++;
            $display("FAIL flush_occ: got %0d want 0", occupancy);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_after_valid: got %b want 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h21 + W'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h21) begin
            n_fail++;
            $display("FAIL arst_pre: got valid %b data %h want 1 21", out_valid, out_data);
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL arst_out: got valid %b data %h want 0 0", out_valid, out_data);
        end
        n_checks++;
        if (stage_valid !== 4'b0000 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_ctl: got sv %b ir %b want 0000 0", stage_valid, in_ready);
        end
        n_checks++;
        if (occupancy !== 3'd0) begin
            n_fail++;
            $display("FAIL arst_occ: got %0d want 0", occupancy);
        end
        m_clear();
        tick();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [D-1:0] esv;
        for (int c = 0; c < 500; c++) begin
            in_valid   = $urandom_range(0, 3) != 0;
            in_data    = $urandom;
            out_ready  = $urandom_range(0, 2) != 0;
            flush      = $urandom_range(0, 31) == 0;
            kill_stage = ($urandom_range(0, 7) == 0) ? D'($urandom) : '0;
            #1;
            esv = m_sv();
            n_checks++;
            if (in_ready !== m_in_ready()) begin
                n_fail++;
                $display("FAIL rnd_in_ready@%0d: got %b want %b", c, in_ready, m_in_ready());
            end
            n_checks++;
            if (stage_valid !== esv) begin
                n_fail++;
                $display("FAIL rnd_stage_valid@%0d: got %b want %b", c, stage_valid, esv);
            end
            n_checks++;
            if (out_valid !== esv[D-1]) begin
                n_fail++;
                $display("FAIL rnd_out_valid@%0d: got %b want %b", c, out_valid, esv[D-1]);
            end
            n_checks++;
            if (occupancy !== OW'(m_occ())) begin
                n_fail++;
                $display("FAIL rnd_occ@%0d: got %0d want %0d", c, occupancy, m_occ());
            end
            if (esv[D-1]) begin
                n_checks++;
                if (out_data !== md[D-1]) begin
                    n_fail++;
                    $display("FAIL rnd_out_data@%0d: got %h want %h", c, out_data, md[D-1]);
                end
            end
            tick();
        end
        in_valid   = 1'b0;
        flush      = 1'b0;
        kill_stage = '0;
    endtask

    initial begin
        m_clear();
        test_reset();
        test_latency();
        test_throughput();
        test_stall_fill();
        test_bubble();
        test_kill();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
